// File: rtl/add32_seq_arb.sv
// Two-requester arbitrated 32-bit adder built around one 8-bit adder slice.
// Each granted add takes four byte cycles (LSB byte first) and then a one-cycle done pulse.
module add32_seq_arb (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    input  logic        cin0,
    input  logic        cin1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        busy,
    output logic        done,
    output logic        done_id,
    output logic [31:0] sum,
    output logic        cout
);

    typedef enum logic [2:0] {IDLE, ADD0, ADD1, ADD2, ADD3, DONE} state_t;

    state_t      state, next_state;
    logic [31:0] op_a, op_b, result;
    logic        carry, owner, last_winner;
    logic        any_req, winner;
    logic [7:0]  slice_a, slice_b, slice_y;
    logic        slice_co;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // On a tie the requester that did not win last time is served.
    always_comb begin
        any_req    = req0 | req1;
        winner     = (req0 && req1) ? ~last_winner : req1;
        next_state = state;
        case (state)
            IDLE:    if (any_req) next_state = ADD0;
            ADD0:    next_state = ADD1;
            ADD1:    next_state = ADD2;
            ADD2:    next_state = ADD3;
            ADD3:    next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The single shared 8-bit slice, fed the byte selected by the current state.
    always_comb begin
        slice_a = op_a[7:0];
        slice_b = op_b[7:0];
        case (state)
            ADD1:    begin slice_a = op_a[15:8];  slice_b = op_b[15:8];  end
            ADD2:    begin slice_a = op_a[23:16]; slice_b = op_b[23:16]; end
            ADD3:    begin slice_a = op_a[31:24]; slice_b = op_b[31:24]; end
            default: begin slice_a = op_a[7:0];   slice_b = op_b[7:0];   end
        endcase
        {slice_co, slice_y} = {1'b0, slice_a} + {1'b0, slice_b} + {8'd0, carry};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            done_id     <= 1'b0;
            sum         <= 32'd0;
            cout        <= 1'b0;
            carry       <= 1'b0;
            last_winner <= 1'b1;
            owner       <= 1'b0;
            op_a        <= 32'd0;
            op_b        <= 32'd0;
            result      <= 32'd0;
        end else begin
            busy <= (next_state != IDLE);
            done <= (next_state == DONE);
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        op_a        <= winner ? a1 : a0;
                        op_b        <= winner ? b1 : b0;
                        carry       <= winner ? cin1 : cin0;
                        owner       <= winner;
                        last_winner <= winner;
                        gnt0        <= ~winner;
                        gnt1        <= winner;
                    end
                end
                ADD0: begin result[7:0]   <= slice_y; carry <= slice_co; end
                ADD1: begin result[15:8]  <= slice_y; carry <= slice_co; end
                ADD2: begin result[23:16] <= slice_y; carry <= slice_co; end
                ADD3: begin
                    // Published result, carry-out and owner change together.
                    result[31:24] <= slice_y;
                    carry         <= slice_co;
                    sum           <= {slice_y, result[23:0]};
                    cout          <= slice_co;
                    done_id       <= owner;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_add32_seq_arb.sv
// Directed self-checking bench for add32_seq_arb; inputs driven and outputs sampled 1ns after each rising edge.
module tb_add32_seq_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, cin0, cin1;
    logic [31:0] a0, b0, a1, b1;
    logic        gnt0, gnt1, busy, done, done_id, cout;
    logic [31:0] sum;

    int tests_run    = 0;
    int tests_failed = 0;

    add32_seq_arb dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .cin0(cin0), .cin1(cin1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
        .done_id(done_id), .sum(sum), .cout(cout)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; cin0 = 1'b0; cin1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        step(2);
        tests_run++;
        if ({gnt0, gnt1, busy, done, done_id, cout} !== 6'b000000) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got %b expected 000000", {gnt0, gnt1, busy, done, done_id, cout});
        end
        tests_run++;
        if (sum !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_sum: got %h expected 00000000", sum);
        end
        reset = 1'b0;
        step(1);
    endtask

    // Single req0 add; a0 changes in the grant cycle and must not matter.
    task automatic test_basic_add;
        req0 = 1'b1; a0 = 32'h0000_00FF; b0 = 32'h0000_0001; cin0 = 1'b0;
        step(1);
        tests_run++;
        if ({gnt0, gnt1, busy} !== 3'b101) begin
            tests_failed++;
            $display("[TB] FAIL basic_grant: got gnt0,gnt1,busy=%b expected 101", {gnt0, gnt1, busy});
        end
        req0 = 1'b0; a0 = 32'h1234_5678;
        step(3);
        tests_run++;
        if ({gnt0, done} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL basic_add3: got gnt0,done=%b expected 00", {gnt0, done});
        end
        step(1);
        tests_run++;
        if ({done, done_id, cout, sum} !== {1'b1, 1'b0, 1'b0, 32'h0000_0100}) begin
            tests_failed++;
            $display("[TB] FAIL basic_done: got done=%b id=%b cout=%b sum=%h expected 1 0 0 00000100",
                     done, done_id, cout, sum);
        end
        step(1);
        tests_run++;
        if ({busy, done, sum} !== {1'b0, 1'b0, 32'h0000_0100}) begin
            tests_failed++;
            $display("[TB] FAIL basic_idle: got busy=%b done=%b sum=%h expected 0 0 00000100", busy, done, sum);
        end
    endtask

    task automatic test_carry_chain;
        req1 = 1'b1; a1 = 32'hFFFF_FFFF; b1 = 32'h0000_0000; cin1 = 1'b1;
        step(1);
        tests_run++;
        if ({gnt0, gnt1} !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL carry_grant: got gnt0,gnt1=%b expected 01", {gnt0, gnt1});
        end
        req1 = 1'b0; cin1 = 1'b0;
        step(4);
        tests_run++;
        if ({done, done_id, cout, sum} !== {1'b1, 1'b1, 1'b1, 32'h0000_0000}) begin
            tests_failed++;
            $display("[TB] FAIL carry_done: got done=%b id=%b cout=%b sum=%h expected 1 1 1 00000000",
                     done, done_id, cout, sum);
        end
        step(1);
    endtask

    // Both requesting from reset release: 0 then 1, dones six cycles apart.
    task automatic test_back_to_back;
        int g0_cyc = -1, g1_cyc = -1, d0_cyc = -1, d1_cyc = -1;
        logic id0 = 1'bx, id1 = 1'bx;
        logic [31:0] s0 = 'x, s1 = 'x;
        logic both = 1'b0;
        reset = 1'b1;
        step(1);
        req0 = 1'b1; a0 = 32'h0000_0001; b0 = 32'h0000_0002; cin0 = 1'b0;
        req1 = 1'b1; a1 = 32'h0000_0010; b1 = 32'h0000_0020; cin1 = 1'b1;
        reset = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            step(1);
            if (gnt0 && gnt1) both = 1'b1;
            if (gnt0 && g0_cyc < 0) begin g0_cyc = c; req0 = 1'b0; end
            if (gnt1 && g1_cyc < 0) begin g1_cyc = c; req1 = 1'b0; end
            if (done && d0_cyc < 0) begin d0_cyc = c; id0 = done_id; s0 = sum; end
            else if (done && d1_cyc < 0) begin d1_cyc = c; id1 = done_id; s1 = sum; end
        end
        req0 = 1'b0; req1 = 1'b0;
        tests_run++;
        if (g0_cyc !== 1 || g1_cyc !== 7 || both) begin
            tests_failed++;
            $display("[TB] FAIL b2b_grant_order: got gnt0@%0d gnt1@%0d overlap=%b expected gnt0@1 gnt1@7 overlap=0",
                     g0_cyc, g1_cyc, both);
        end
        tests_run++;
        if (d0_cyc !== 5 || d1_cyc !== 11) begin
            tests_failed++;
            $display("[TB] FAIL b2b_done_timing: got done@%0d,%0d expected done@5,11", d0_cyc, d1_cyc);
        end
        tests_run++;
        if ({id0, id1} !== 2'b01 || s0 !== 32'h0000_0003 || s1 !== 32'h0000_0031) begin
            tests_failed++;
            $display("[TB] FAIL b2b_results: got ids=%b%b sums=%h,%h expected ids=01 sums=00000003,00000031",
                     id0, id1, s0, s1);
        end
    endtask

    // After req0 wins alone, a simultaneous tie must go to req1.
    task automatic test_tie_fairness;
        req0 = 1'b1; a0 = 32'h0000_0005; b0 = 32'h0000_0005; cin0 = 1'b0;
        step(1);
        req0 = 1'b0;
        step(5);
        req0 = 1'b1; req1 = 1'b1; a1 = 32'h0000_0100; b1 = 32'h0000_0200; cin1 = 1'b0;
        step(1);
        tests_run++;
        if ({gnt0, gnt1} !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL tie_fairness: got gnt0,gnt1=%b expected 01", {gnt0, gnt1});
        end
        req1 = 1'b0;
        step(4);
        tests_run++;
        if ({done, done_id, sum} !== {1'b1, 1'b1, 32'h0000_0300}) begin
            tests_failed++;
            $display("[TB] FAIL tie_result: got done=%b id=%b sum=%h expected 1 1 00000300", done, done_id, sum);
        end
        // req0 is still high and is served at the next IDLE sample.
        step(2);
        tests_run++;
        if ({gnt0, gnt1} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL tie_pending_req0: got gnt0,gnt1=%b expected 10", {gnt0, gnt1});
        end
        req0 = 1'b0;
        step(5);
    endtask

    task automatic test_late_request;
        logic early_gnt1 = 1'b0;
        req0 = 1'b1; a0 = 32'h0101_0101; b0 = 32'h0202_0202; cin0 = 1'b0;
        step(1);
        req0 = 1'b0;
        step(1);
        req1 = 1'b1; a1 = 32'hAAAA_0000; b1 = 32'h0000_5555; cin1 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step(1);
            if (gnt1) early_gnt1 = 1'b1;
        end
        tests_run++;
        if (early_gnt1) begin
            tests_failed++;
            $display("[TB] FAIL late_no_early_gnt1: got gnt1=1 before IDLE expected 0");
        end
        tests_run++;
        if ({done, done_id, sum} !== {1'b0, 1'b0, 32'h0303_0303}) begin
            tests_failed++;
            $display("[TB] FAIL late_req0_result: got done=%b id=%b sum=%h expected 0 0 03030303 (one past DONE)",
                     done, done_id, sum);
        end
        step(1);
        tests_run++;
        if (gnt1 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL late_gnt1: got %b expected 1", gnt1);
        end
        req1 = 1'b0;
        step(4);
        tests_run++;
        if ({done, done_id, cout, sum} !== {1'b1, 1'b1, 1'b0, 32'hAAAA_5556}) begin
            tests_failed++;
            $display("[TB] FAIL late_req1_result: got done=%b id=%b cout=%b sum=%h expected 1 1 0 aaaa5556",
                     done, done_id, cout, sum);
        end
        step(1);
    endtask

    task automatic test_reset_mid_op;
        logic saw_done = 1'b0;
        req0 = 1'b1; a0 = 32'hFFFF_0000; b0 = 32'h0001_0000; cin0 = 1'b0;
        step(1);
        req0 = 1'b0;
        step(2);
        reset = 1'b1;
        step(1);
        tests_run++;
        if ({busy, done, cout, sum} !== {1'b0, 1'b0, 1'b0, 32'd0}) begin
            tests_failed++;
            $display("[TB] FAIL midreset_state: got busy=%b done=%b cout=%b sum=%h expected 0 0 0 00000000",
                     busy, done, cout, sum);
        end
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step(1);
            if (done || busy) saw_done = 1'b1;
        end
        tests_run++;
        if (saw_done) begin
            tests_failed++;
            $display("[TB] FAIL midreset_no_done: got activity after abort expected none");
        end
        req1 = 1'b1; a1 = 32'h0000_0005; b1 = 32'h0000_0007; cin1 = 1'b0;
        step(1);
        req1 = 1'b0;
        step(4);
        tests_run++;
        if ({done, done_id, cout, sum} !== {1'b1, 1'b1, 1'b0, 32'h0000_000C}) begin
            tests_failed++;
            $display("[TB] FAIL midreset_recover: got done=%b id=%b cout=%b sum=%h expected 1 1 0 0000000c",
                     done, done_id, cout, sum);
        end
        step(1);
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_carry_chain();
        test_back_to_back();
        test_tie_fairness();
        test_late_request();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/add32_seq_arb.md
ADD32_SEQ_ARB -- requirements
Module: add32_seq_arb

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 req0, req1  input  1 each  requester 0/1 add request, level, held until gntN seen.
REQ-005 a0, b0, a1, b1  input  32 each  requester operands, valid while reqN high.
REQ-006 cin0, cin1  input  1 each  requester carry-in.
REQ-007 gnt0, gnt1  output  1 each  one-cycle grant pulse; operands captured.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle result-valid pulse.
REQ-010 done_id  output  1  owner of the current result (0/1).
REQ-011 sum  output  32  result of the last completed add; holds until the next done.
REQ-012 cout  output  1  carry-out of the last completed add; holds with sum.

Function
REQ-013 The block SHALL compute one 32-bit add (A + B + Cin) per grant using a single internal 8-bit adder slice (8-bit A, B, Ci in; 8-bit Y, Co out), one byte per cycle, LSB byte first.
REQ-014 States: IDLE, ADD0, ADD1, ADD2, ADD3, DONE; all outputs registered.
REQ-015 IDLE, no req: remain IDLE.
REQ-016 IDLE, any req sampled at an edge: latch the winner's a, b, and cin into opA, opB, and the carry register; record the owner; go to ADD0; assert the winner's gnt during ADD0 only.
REQ-017 Arbitration: single request wins; on a tie, the requester not granted last time wins; last_winner resets to 1, so req0 wins the first tie.
REQ-018 ADDk (k=0..3), edge: result byte k = slice(opA byte k, opB byte k, carry); carry <= slice Co; go to ADD(k+1), or to DONE from ADD3.
REQ-019 The working result register SHALL be separate from sum/cout. At the ADD3 edge, sum, cout, and done_id update together, and done=1 during DONE.
REQ-020 DONE -> IDLE unconditionally; done is low in all other states.
REQ-021 req is sampled only in IDLE. req seen in ADD0..DONE is ignored for arbitration; a still-high req is served at the next IDLE.
REQ-022 Timing: request-sampling edge at T; gnt high in T+1 cycle; done high in T+5 cycle. Minimum repeat period 6 cycles.
REQ-023 Operand changes after the grant edge SHALL NOT affect the result.
REQ-024 gnt0 and gnt1 are never high together; at most one add is in flight.
REQ-025 Carry propagates byte-to-byte within the operation only. Cout is the ADD3 slice carry, and 32-bit wrap-around is normal, not an error.

Reset
REQ-026 Reset SHALL dominate all other inputs at an edge, including mid-operation.
REQ-027 Reset values:
- state=IDLE
- gnt0=gnt1=0, busy=0, done=0, done_id=0
- sum=0, cout=0, carry=0, last_winner=1
REQ-028 A reset during ADD0..DONE SHALL abort the operation with no done pulse. Requests still high after reset release are served normally.

Verification
REQ-029 req0, a0=0x000000FF, b0=0x00000001, cin0=0 -> gnt0 at T+1; done at T+5 with sum=0x00000100, cout=0, done_id=0.
REQ-030 req1, a1=0xFFFFFFFF, b1=0x00000000, cin1=1 -> done with sum=0x00000000, cout=1, done_id=1 (full byte-chain carry).
REQ-031 req0 and req1 held high from reset release, each dropped on its gnt -> grant order 0 then 1; done_id sequence 0,1; second done 6 cycles after the first.
REQ-032 req1 asserted during req0's ADD1 -> no gnt1 before DONE; gnt1 in the cycle after the IDLE sampling edge; req0 result unchanged by a1/b1.
REQ-033 reset pulsed during ADD2 -> next cycle busy=0, sum=0, cout=0; no done; a subsequent request completes correctly.
REQ-034 a0 changed to 0x12345678 in the gnt0 cycle -> result reflects the latched operand only.
